// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator control: ratio register, flush/run sequencing, 2-entry output FIFO
module cic_decim_ctrl #(
    parameter int RATIO_W       = 4,
    parameter int DATA_W        = 7,
    parameter int SETTLE        = 4,
    parameter int DEFAULT_RATIO = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic              cfg_load,
    output logic              integ_clr,
    output logic              comb_strobe,
    input  logic [DATA_W-1:0] comb_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              running
);

    localparam int SCNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    // Ratio is stored as R-1 so it compares directly against the phase counter.
    localparam logic [RATIO_W-1:0] DEF_RMAX = RATIO_W'(DEFAULT_RATIO - 1);
    localparam logic [SCNT_W-1:0]  LAST_FLUSH = SCNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [RATIO_W-1:0]  rmax;
    logic [RATIO_W-1:0]  cnt;
    logic [SCNT_W-1:0]   scnt;
    logic [DATA_W-1:0]   mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fcnt;
    logic                push;
    logic                pop;
    logic                full;
    logic                do_push;
    logic                load_ok;
    logic                start;

    // Next-state and state-decoded outputs; the strobe depends only on state and counter.
    always_comb begin
        state_nxt   = state;
        integ_clr   = 1'b0;
        running     = 1'b0;
        comb_strobe = 1'b0;
        if (state != S_IDLE && cnt == rmax) begin
            comb_strobe = 1'b1;
        end
        case (state)
            S_IDLE: begin
                integ_clr = 1'b1;
                if (enable) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (comb_strobe && scnt == LAST_FLUSH) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                running = 1'b1;
                if (!enable) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign start     = (state == S_IDLE) && enable;
    assign load_ok   = (state == S_IDLE) && cfg_load;
    assign push      = comb_strobe && (state == S_RUN);
    assign pop       = out_valid && out_ready;
    assign full      = (fcnt == 2'd2);
    assign do_push   = push && (!full || pop);
    assign out_valid = (fcnt != 2'd0);
    assign out_data  = mem[rd_ptr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ratio register, writable only while idle; a zero request is clamped to ratio 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmax <= DEF_RMAX;
        end else if (load_ok) begin
            rmax <= (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;
        end
    end

    // Phase counter: parked at 0 in IDLE and on the edge that returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_IDLE || !enable) begin
            cnt <= '0;
        end else if (cnt == rmax) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + RATIO_W'(1);
        end
    end

    // Counts discarded strobes while the comb pipeline settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
        end else if (state != S_FLUSH) begin
            scnt <= '0;
        end else if (comb_strobe) begin
            scnt <= scnt + SCNT_W'(1);
        end
    end

    // Output FIFO; no bypass, so a sample is visible the cycle after its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fcnt   <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= comb_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fcnt <= fcnt + {1'b0, do_push} - {1'b0, pop};
        end
    end

    // Sticky drop flag, cleared by a fresh configuration or a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (load_ok || start) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - randomized model-checked bench for cic_decim_ctrl
module tb_cic_decim_ctrl;

    localparam int RATIO_W = 4;
    localparam int DATA_W  = 7;
    localparam int SETTLE  = 4;
    localparam int DEF_R   = 12;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               cfg_load;
    logic               integ_clr;
    logic               comb_strobe;
    logic [DATA_W-1:0]  comb_data;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;
    logic               running;

    int checks = 0;
    int errors = 0;

    // Model: time since start, strobes seen, ratio, queue of buffered samples.
    bit                m_active;
    int                m_t;
    int                m_strobes;
    int                m_r;
    bit                m_ovr;
    logic [DATA_W-1:0] m_q[$];

    cic_decim_ctrl #(
        .RATIO_W(RATIO_W), .DATA_W(DATA_W), .SETTLE(SETTLE), .DEFAULT_RATIO(DEF_R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_ratio(cfg_ratio),
        .cfg_load(cfg_load), .integ_clr(integ_clr), .comb_strobe(comb_strobe),
        .comb_data(comb_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_t       = 0;
        m_strobes = 0;
        m_r       = DEF_R;
        m_ovr     = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit strobe, run, pop, push, was_full;
        strobe   = m_active && (m_t % m_r == 0);
        run      = m_active && (m_strobes >= SETTLE);
        pop      = (m_q.size() > 0) && out_ready;
        push     = strobe && run;
        was_full = (m_q.size() == 2);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (was_full && !pop) m_ovr = 1'b1;
            else m_q.push_back(comb_data);
        end
        if (strobe) m_strobes++;
        if (!m_active) begin
            if (cfg_load) begin
                m_r   = (cfg_ratio == 0) ? 2 : int'(cfg_ratio) + 1;
                m_ovr = 1'b0;
            end
            if (enable) begin
                m_active  = 1'b1;
                m_t       = 1;
                m_strobes = 0;
                m_ovr     = 1'b0;
            end
        end else if (!enable) begin
            m_active = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic compare();
        chk("integ_clr", integ_clr, !m_active);
        chk("running", running, m_active && (m_strobes >= SETTLE));
        chk("comb_strobe", comb_strobe, m_active && (m_t % m_r == 0));
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("overrun", overrun, m_ovr);
        if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (!comb_strobe && n < 64) begin
            cycle();
            n++;
        end
        if (!comb_strobe) chk("strobe_timeout", 0, 1);
    endtask

    initial begin
        int n;
        logic [DATA_W-1:0] dv [3];
        rst_n = 1'b0; enable = 1'b0; cfg_ratio = '0; cfg_load = 1'b0;
        comb_data = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_integ_clr", integ_clr, 1);
        chk("rst_comb_strobe", comb_strobe, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_running", running, 0);
        rst_n = 1'b1;
        cycle();

        // Default ratio: strobes every 12 cycles, four settle strobes dropped.
        enable = 1'b1; out_ready = 1'b1; comb_data = 7'h55;
        wait_strobe(n);
        chk("first_strobe_cycle", n, 12);
        cycle(); wait_strobe(n);
        chk("default_period", n + 1, 12);
        cycle(); wait_strobe(n);
        cycle(); wait_strobe(n);
        chk("running_before_4th", running, 0);
        cycle();
        chk("running_after_4th", running, 1);
        wait_strobe(n);
        chk("valid_at_5th_strobe", out_valid, 0);
        cycle();
        chk("valid_after_5th", out_valid, 1);
        chk("data_after_5th", out_data, 7'h55);

        // Ratio 3, run-time load ignored, overrun with a stalled consumer.
        enable = 1'b0; cycle();
        cfg_ratio = 4'd2; cfg_load = 1'b1; cycle();
        cfg_load = 1'b0; enable = 1'b1; out_ready = 1'b0;
        wait_strobe(n);
        chk("first_strobe_r3", n, 3);
        cycle();
        repeat (3) begin wait_strobe(n); cycle(); end
        cfg_ratio = 4'd7; cfg_load = 1'b1; cycle();
        cfg_load = 1'b0;
        dv[0] = 7'h11; dv[1] = 7'h22; dv[2] = 7'h33;
        for (int i = 0; i < 3; i++) begin
            wait_strobe(n);
            if (i > 0) chk("period_after_run_load", n + 1, 3);
            comb_data = dv[i];
            cycle();
        end
        chk("full_valid", out_valid, 1);
        chk("full_head", out_data, 7'h11);
        chk("full_overrun", overrun, 1);
        enable = 1'b0; out_ready = 1'b1;
        cycle();
        chk("drain_second", out_data, 7'h22);
        chk("drain_valid", out_valid, 1);
        chk("idle_integ_clr", integ_clr, 1);
        cycle();
        chk("drained", out_valid, 0);
        chk("overrun_sticky", overrun, 1);
        enable = 1'b1; cycle();
        chk("overrun_cleared", overrun, 0);
        chk("reenable_integ_clr", integ_clr, 0);

        // Zero request clamps to ratio 2.
        enable = 1'b0; cycle();
        cfg_ratio = 4'd0; cfg_load = 1'b1; cycle();
        cfg_load = 1'b0; enable = 1'b1;
        wait_strobe(n);
        chk("first_strobe_r2", n, 2);
        cycle(); wait_strobe(n);
        chk("period_r2", n + 1, 2);

        // Random traffic against the model, with occasional asynchronous resets.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare();
                cycle();
                rst_n = 1'b1;
                continue;
            end
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            cfg_load  = ($urandom_range(0, 9) == 0);
            cfg_ratio = ($urandom_range(0, 7) == 0) ? RATIO_W'($urandom) : RATIO_W'($urandom_range(0, 4));
            out_ready = ($urandom_range(0, 9) < 6);
            comb_data = DATA_W'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
